// File: rtl/fir_inverse_n_pkg.sv
// Shared types and helpers for the all-pole FIR inverse.
// Provides the FSM state type and a tap-slice helper for packed coefficient vectors.
package fir_inverse_n_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } fir_inv_state_t;

  // Upper bounds for the generic tap() helper; callers zero-extend into this width.
  localparam int unsigned MaxN    = 64;
  localparam int unsigned MaxTaps = 17;
  localparam int unsigned MaxBW   = MaxN * MaxTaps;

  // Returns b[k*n +: n] in the low bits; callers truncate to their own width.
  function automatic logic [MaxN-1:0] tap(input logic [MaxBW-1:0] b,
                                          input int unsigned      k,
                                          input int unsigned      n);
    logic [MaxBW-1:0] s;
    s = b >> (k * n);
    return s[MaxN-1:0];
  endfunction

endpackage

// File: rtl/fir_inverse_n_if.sv
// Data/status bundle between a sample source and the FIR inverse.
// The master drives samples and taps; the slave returns the recovered sample and status.
interface fir_inverse_n_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned DELAYS = 3
);
  logic                      ena;
  logic [N-1:0]              y_in;
  logic [(DELAYS+1)*N-1:0]   b;
  logic [N-1:0]              x_out;
  logic                      x_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output ena,
    output y_in,
    output b,
    input  x_out,
    input  x_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  ena,
    input  y_in,
    input  b,
    output x_out,
    output x_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/fir_inverse_n_sample_strobe.sv
// Rising-edge detector for the sample-rate clock, sampled in the system clock domain.
// Two flops: the first captures clk_d, the second holds its previous value.
module sample_strobe (
  input  logic clk,
  input  logic rst,
  input  logic clk_d,
  output logic start
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= clk_d;
      prev_q <= sync_q;
    end
  end

  assign start = sync_q & ~prev_q;

endmodule

// File: rtl/fir_inverse_n.sv
// All-pole inverse of a monic FIR: x[n] = y[n] - sum_k b_k * x[n-k], mod 2^N.
// One shared multiplier walks the feedback taps, one tap per system clock.
module fir_inverse_n
  import fir_inverse_n_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned DELAYS = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_d,
  fir_inverse_n_if.slave io
);

  localparam int unsigned KW = $clog2(DELAYS + 1);

  logic start;

  fir_inv_state_t state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   hist_q [DELAYS];
  logic [N-1:0]   hist_d [DELAYS];
  logic [N-1:0]   x_out_q, x_out_d;
  logic           x_valid_q, x_valid_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;

  logic [N-1:0]   tap_b;
  logic [N-1:0]   hist_sel;
  logic [N-1:0]   prod;

  sample_strobe u_strobe (
    .clk   (clk),
    .rst   (rst),
    .clk_d (clk_d),
    .start (start)
  );

  // Operand selection for the single multiplier: tap k against x[n-k].
  always_comb begin
    tap_b    = N'(tap(MaxBW'(io.b), 32'(k_q), N));
    hist_sel = '0;
    for (int unsigned i = 0; i < DELAYS; i++) begin
      if (32'(k_q) == i + 1) begin
        hist_sel = hist_q[i];
      end
    end
    // Low N bits of a signed product equal those of the unsigned product.
    prod = tap_b * hist_sel;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    hist_d    = hist_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (start && io.ena) begin
          acc_d   = io.y_in;
          k_d     = KW'(1);
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q - prod;
        k_d   = k_q + KW'(1);
        if (32'(k_q) == DELAYS) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        x_out_d   = acc_q;
        x_valid_d = 1'b1;
        busy_d    = 1'b0;
        for (int unsigned i = DELAYS - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = acc_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new sample edge during a computation is dropped and flagged until reset.
    if (start && busy_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < DELAYS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      hist_q    <= hist_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign io.x_out   = x_out_q;
  assign io.x_valid = x_valid_q;
  assign io.busy    = busy_q;
  assign io.overrun = overrun_q;

endmodule

// File: tb/tb_fir_inverse_n.sv
// Scoreboard bench for fir_inverse_n: stimulus pushes expected samples, a monitor checks them.
// Expectations come from the recurrence itself or from a forward FIR whose inverse is the input.
module tb_fir_inverse_n;

  localparam int unsigned N      = 32;
  localparam int unsigned DELAYS = 3;
  localparam int unsigned HALF   = 8;
  localparam int          LAT    = DELAYS + 3;

  typedef struct {
    logic [N-1:0] val;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_d = 1'b0;
  int   cyc = 0;

  fir_inverse_n_if #(.N(N), .DELAYS(DELAYS)) io ();

  fir_inverse_n #(.N(N), .DELAYS(DELAYS)) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_d (clk_d),
    .io    (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t         sb [$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] bt [DELAYS+1];
  logic [N-1:0] mh [DELAYS];
  logic [N-1:0] fh [DELAYS];
  logic [N-1:0] imp [5];

  function automatic void check(input string name, input logic [N-1:0] act,
                                input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Recurrence x = y - sum b_k x[n-k]; mh[0] is the most recent output.
  function automatic logic [N-1:0] model_step(input logic [N-1:0] y);
    logic [N-1:0] x;
    x = y;
    for (int k = 1; k <= int'(DELAYS); k++) x = x - bt[k] * mh[k-1];
    for (int i = int'(DELAYS) - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
    return x;
  endfunction

  // Forward monic FIR (tap 0 treated as 1), used to build invertible inputs.
  function automatic logic [N-1:0] fir_step(input logic [N-1:0] x);
    logic [N-1:0] y;
    y = x;
    for (int k = 1; k <= int'(DELAYS); k++) y = y + bt[k] * fh[k-1];
    for (int i = int'(DELAYS) - 1; i > 0; i--) fh[i] = fh[i-1];
    fh[0] = x;
    return y;
  endfunction

  task automatic set_b();
    for (int k = 0; k <= int'(DELAYS); k++) io.b[k*N +: N] = bt[k];
  endtask

  task automatic std_b();
    for (int k = 0; k <= int'(DELAYS); k++) bt[k] = N'(k + 1);
    set_b();
  endtask

  task automatic push(input logic [N-1:0] v);
    exp_t e;
    e.val = v;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    clk_d = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x_out", io.x_out, 0);
    check("rst_busy", N'(io.busy), 0);
    check("rst_overrun", N'(io.overrun), 0);
    check("rst_x_valid", N'(io.x_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < int'(DELAYS); i++) begin
      mh[i] = '0;
      fh[i] = '0;
    end
  endtask

  // One full clk_d period; the expected output is pushed at the rising edge.
  task automatic sample(input logic [N-1:0] y, input bit expect_out, input logic [N-1:0] v);
    @(negedge clk);
    io.y_in = y;
    clk_d   = 1'b1;
    if (expect_out) push(v);
    repeat (3) @(negedge clk);
    if (expect_out) check("busy_mid", N'(io.busy), 1);
    repeat (HALF - 3) @(negedge clk);
    clk_d = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_idle", N'(io.busy), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && io.x_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_x_valid: x_out=%0h with nothing expected", io.x_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_out", io.x_out, e.val);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] last;
    int           waited;

    imp[0] = 32'd255;
    imp[1] = 32'hFFFF_FE02;
    imp[2] = 32'd255;
    imp[3] = 32'd0;
    imp[4] = 32'd1275;
    io.ena  = 1'b1;
    io.y_in = '0;
    std_b();

    // Reset and quiet input
    do_reset();
    for (int i = 0; i < 5; i++) sample('0, 1'b1, model_step('0));
    check("overrun_quiet", N'(io.overrun), 0);

    // Impulse response against the hand-derived table
    for (int i = 0; i < 5; i++) begin
      y = (i == 0) ? 32'd255 : 32'd0;
      void'(model_step(y));
      sample(y, 1'b1, imp[i]);
    end

    // Cascade: forward FIR followed by the DUT returns the original samples
    do_reset();
    for (int i = 0; i < 204; i++) begin
      x = (i < 4) ? ((i == 0) ? 32'd255 : 32'd0) : $urandom;
      y = fir_step(x);
      void'(model_step(y));
      sample(y, 1'b1, x);
    end

    // Random taps (tap 0 deliberately garbage) through the cascade and the recurrence
    do_reset();
    for (int k = 0; k <= int'(DELAYS); k++) bt[k] = $urandom;
    set_b();
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = fir_step(x);
      void'(model_step(y));
      sample(y, 1'b1, x);
    end
    for (int i = 0; i < 40; i++) begin
      y = $urandom;
      sample(y, 1'b1, model_step(y));
    end

    // Overrun: second clk_d rise two clocks after the first
    do_reset();
    std_b();
    @(negedge clk);
    io.y_in = 32'd255;
    clk_d   = 1'b1;
    push(model_step(32'd255));
    @(negedge clk);
    clk_d = 1'b0;
    @(negedge clk);
    clk_d = 1'b1;
    repeat (HALF) @(negedge clk);
    clk_d = 1'b0;
    repeat (HALF) @(negedge clk);
    check("overrun_set", N'(io.overrun), 1);
    sample('0, 1'b1, model_step('0));
    check("overrun_sticky", N'(io.overrun), 1);

    // Enable low: no outputs, x_out held
    do_reset();
    last = model_step(32'd255);
    sample(32'd255, 1'b1, last);
    io.ena = 1'b0;
    for (int i = 0; i < 3; i++) sample($urandom, 1'b0, '0);
    check("x_out_held", io.x_out, last);
    io.ena = 1'b1;

    // Enable drops mid-MAC: that sample still completes
    @(negedge clk);
    io.y_in = '0;
    clk_d   = 1'b1;
    push(model_step('0));
    repeat (3) @(negedge clk);
    io.ena = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    clk_d = 1'b0;
    repeat (HALF) @(negedge clk);
    sample(32'd5, 1'b0, '0);
    io.ena = 1'b1;

    // Reset mid-MAC: no output, history cleared, impulse reproduces the table
    @(negedge clk);
    io.y_in = 32'd1234;
    clk_d   = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    clk_d = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(DELAYS); i++) mh[i] = '0;
    repeat (HALF) @(negedge clk);
    check("rst_mid_x_out", io.x_out, 0);
    check("rst_mid_busy", N'(io.busy), 0);
    for (int i = 0; i < 5; i++) begin
      y = (i == 0) ? 32'd255 : 32'd0;
      void'(model_step(y));
      sample(y, 1'b1, imp[i]);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d outputs outstanding, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
